pipelined_alu: RTL and testbench

Parametrised, handshaked successor to the team's combinational ALU. It accepts one operation at a time over a valid/ready input channel and registers the result and a 4-bit status word (PSR). It holds the result on a valid/ready output channel until the result is consumed. It adds XOR, unsigned compare and shifts, plus an optional iterative multiplier, and sits between the datapath register file and the writeback stage.

---
 rtl/pipelined_alu_pkg.sv | 27 ++
 rtl/pipelined_alu_if.sv | 27 ++
 rtl/pipelined_alu_alu_comb.sv | 60 ++++++
 rtl/pipelined_alu.sv | 113 +++++++++++
 tb/tb_pipelined_alu.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_alu_pkg.sv
// Shared constants for the pipelined ALU: opcodes, PSR bit indices, FSM states.
// Opcode 11 (MUL) is only implemented when PIPELINED_ALU_MUL_EN is defined.
package pipelined_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam int PSR_Z = 0;
    localparam int PSR_N = 1;
    localparam int PSR_C = 2;
    localparam int PSR_V = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/pipelined_alu_if.sv
// Operand/result channel of the pipelined ALU: valid/ready in, valid/ready out.
interface pipelined_alu_if #(
    parameter int WIDTH = 32
);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic [3:0]       OPCode;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RES;
    logic [3:0]       PSR;
    logic             ERR;

    modport master (
        output IN_VALID, OP1, OP2, OPCode, OUT_READY,
        input  IN_READY, OUT_VALID, RES, PSR, ERR
    );

    modport slave (
        input  IN_VALID, OP1, OP2, OPCode, OUT_READY,
        output IN_READY, OUT_VALID, RES, PSR, ERR
    );

endinterface

// File: rtl/pipelined_alu_alu_comb.sv
// Combinational core: result, flags and error for every single-cycle opcode.
module alu_comb
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       psr,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    logic             sub;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   sh;
    logic             c;
    logic             v;

    // SUB shares the adder as op1 + ~op2 + 1
    assign sub = (opcode == OP_SUB);
    assign b   = sub ? ~op2 : op2;
    assign sum = {1'b0, op1} + {1'b0, b} + {{WIDTH{1'b0}}, sub};
    assign sh  = op2[SHW-1:0];

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (op1[WIDTH-1] == b[WIDTH-1])
                    && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_OR:   res = op1 | op2;
            OP_AND:  res = op1 & op2;
            OP_NOR:  res = ~(op1 | op2);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_XOR:  res = op1 ^ op2;
            OP_SLL:  res = op1 << sh;
            OP_SRL:  res = op1 >> sh;
            OP_SRA:  res = $unsigned($signed(op1) >>> sh);
            default: err = 1'b1;
        endcase
        psr        = '0;
        psr[PSR_Z] = (res == '0);
        psr[PSR_N] = res[WIDTH-1];
        psr[PSR_C] = c;
        psr[PSR_V] = v;
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU with registered RES/PSR/ERR held until consumed.
// Define PIPELINED_ALU_MUL_EN to add the iterative shift-add multiplier (opcode 11).
module pipelined_alu
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic             CLK,
    input logic             RST,
    pipelined_alu_if.slave  bus
);

    logic [1:0]       state;
    logic [WIDTH-1:0] res;
    logic [3:0]       psr;
    logic             err;
    logic [WIDTH-1:0] c_res;
    logic [3:0]       c_psr;
    logic             c_err;
    logic             accept;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op1    (bus.OP1),
        .op2    (bus.OP2),
        .opcode (bus.OPCode),
        .res    (c_res),
        .psr    (c_psr),
        .err    (c_err)
    );

    assign accept        = bus.IN_VALID && (state == ST_IDLE);
    assign bus.IN_READY  = (state == ST_IDLE);
    assign bus.OUT_VALID = (state == ST_HOLD);
    assign bus.RES       = res;
    assign bus.PSR       = psr;
    assign bus.ERR       = err;

`ifdef PIPELINED_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            res   <= '0;
            psr   <= '0;
            err   <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef PIPELINED_ALU_MUL_EN
                        if (bus.OPCode == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, bus.OP1};
                            mplier <= bus.OP2;
                            cnt    <= CW'(WIDTH);
                            state  <= ST_MUL;
                        end else begin
                            res   <= c_res;
                            psr   <= c_psr;
                            err   <= c_err;
                            state <= ST_HOLD;
                        end
`else
                        res   <= c_res;
                        psr   <= c_psr;
                        err   <= c_err;
                        state <= ST_HOLD;
`endif
                    end
                end
`ifdef PIPELINED_ALU_MUL_EN
                ST_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // last step: publish the low half, C flags upper-half overflow
                    if (cnt == CW'(1)) begin
                        res        <= acc_nx[WIDTH-1:0];
                        psr[PSR_Z] <= (acc_nx[WIDTH-1:0] == '0);
                        psr[PSR_N] <= acc_nx[WIDTH-1];
                        psr[PSR_C] <= |acc_nx[2*WIDTH-1:WIDTH];
                        psr[PSR_V] <= 1'b0;
                        err        <= 1'b0;
                        state      <= ST_HOLD;
                    end
                end
`endif
                ST_HOLD: begin
                    if (bus.OUT_READY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu against a plain-arithmetic reference model.
// Honours PIPELINED_ALU_MUL_EN to select the MUL or undefined-opcode-11 checks.
module tb_pipelined_alu;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errs = 0;
    int   checks = 0;

    pipelined_alu_if #(.WIDTH(W)) bus ();

    pipelined_alu #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  psr;
        logic        err;
    } exp_t;

    function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t   r;
        longint sa;
        longint sb;
        longint s;
        logic [63:0] u;
        logic c;
        logic v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r.err = 1'b0;
        r.res = '0;
        case (op)
            4'd0: begin
                u = {32'b0, a} + {32'b0, b};
                r.res = u[31:0];
                c = u[32];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r.res = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  r.res = a | b;
            4'd3:  r.res = a & b;
            4'd4:  r.res = ~(a | b);
            4'd5:  r.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  r.res = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r.res = a ^ b;
            4'd8:  r.res = a << b[4:0];
            4'd9:  r.res = a >> b[4:0];
            4'd10: r.res = $signed(a) >>> b[4:0];
`ifdef PIPELINED_ALU_MUL_EN
            4'd11: begin
                u = {32'b0, a} * {32'b0, b};
                r.res = u[31:0];
                c = (u[63:32] != 0);
            end
`endif
            default: r.err = 1'b1;
        endcase
        r.psr = {v, c, r.res[31], r.res == 0};
        return r;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int n = 0;
        while (!bus.IN_READY && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (!bus.IN_READY) begin
            errs++;
            $display("FAIL issue_timeout: IN_READY=%b required 1", bus.IN_READY);
        end
        bus.OPCode   = op;
        bus.OP1      = a;
        bus.OP2      = b;
        bus.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic consume();
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 ||
            bus.RES !== 32'd0 || bus.PSR !== 4'd0 || bus.ERR !== 1'b0) begin
            errs++;
            $display("FAIL reset_init: ov=%b ir=%b res=%h psr=%b err=%b required 0 1 0 0 0",
                     bus.OUT_VALID, bus.IN_READY, bus.RES, bus.PSR, bus.ERR);
        end
        issue(4'd0, 32'd3, 32'd4);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.RES !== 32'd7) begin
            errs++;
            $display("FAIL reset_pre: ov=%b res=%h required 1 7", bus.OUT_VALID, bus.RES);
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errs++;
            $display("FAIL reset_ov: got %b required 0", bus.OUT_VALID);
        end
        checks++;
        if (bus.RES !== 32'd0 || bus.PSR !== 4'd0 || bus.ERR !== 1'b0) begin
            errs++;
            $display("FAIL reset_regs: res=%h psr=%b err=%b required 0 0 0",
                     bus.RES, bus.PSR, bus.ERR);
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL reset_ir: got %b required 1", bus.IN_READY);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd10, 4'd13};
        logic [31:0] as   [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h80000000, 32'd9};
        logic [31:0] bs   [6] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h21, 32'd9};
        logic [31:0] eres [6] = '{32'h80000000, 32'd0, 32'd1, 32'd0,
                                  32'hC0000000, 32'd0};
        logic [3:0]  epsr [6] = '{4'b1010, 4'b0101, 4'b0000, 4'b0001,
                                  4'b0010, 4'b0001};
        logic        eerr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.RES !== eres[i] ||
                bus.PSR !== epsr[i] || bus.ERR !== eerr[i]) begin
                errs++;
                $display("FAIL directed[%0d] op=%0d: ov=%b res=%h psr=%b err=%b required 1 %h %b %b",
                         i, ops[i], bus.OUT_VALID, bus.RES, bus.PSR, bus.ERR,
                         eres[i], epsr[i], eerr[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF,
                                   32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            exp_t        e;
            int          n;
            int          elat;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 2) == 0) a = edges[$urandom_range(0, 4)];
            if ($urandom_range(0, 2) == 0) b = edges[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
            e = model(op, a, b);
            issue(op, a, b);
            n = 0;
            while (!bus.OUT_VALID && n < 100) begin
                @(posedge CLK);
                #1;
                n++;
            end
            elat = 1;
`ifdef PIPELINED_ALU_MUL_EN
            if (op == 4'd11) elat = W + 1;
`endif
            checks++;
            if (n + 1 !== elat || bus.OUT_VALID !== 1'b1) begin
                errs++;
                $display("FAIL rand_lat[%0d] op=%0d: latency %0d required %0d",
                         i, op, n + 1, elat);
            end
            checks++;
            if (bus.RES !== e.res || bus.PSR !== e.psr || bus.ERR !== e.err) begin
                errs++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: res=%h psr=%b err=%b required %h %b %b",
                         i, op, a, b, bus.RES, bus.PSR, bus.ERR, e.res, e.psr, e.err);
            end
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_res;
        exp_res = 32'hA5A5F00F ^ 32'h0FF00FF0;
        issue(4'd7, 32'hA5A5F00F, 32'h0FF00FF0);
        for (int i = 0; i < 5; i++) begin
            bus.OPCode   = 4'd0;
            bus.OP1      = 32'd1000 + i;
            bus.OP2      = 32'd1;
            bus.IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 ||
                bus.RES !== exp_res || bus.PSR !== 4'b0010 || bus.ERR !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b res=%h psr=%b required 1 0 %h 0010",
                         i, bus.OUT_VALID, bus.IN_READY, bus.RES, bus.PSR, exp_res);
            end
        end
        bus.IN_VALID = 1'b0;
        consume();
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: ov=%b ir=%b required 0 1",
                     bus.OUT_VALID, bus.IN_READY);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.RES !== exp_res) begin
            errs++;
            $display("FAIL bp_ignored: ov=%b res=%h required 0 %h",
                     bus.OUT_VALID, bus.RES, exp_res);
        end
    endtask

    task automatic test_back_to_back();
        bus.OPCode    = 4'd0;
        bus.OP1       = 32'd100;
        bus.OP2       = 32'd23;
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic ev;
            @(posedge CLK);
            #1;
            ev = (i % 2 == 0);
            if (i == 9) bus.IN_VALID = 1'b0;
            checks++;
            if (bus.OUT_VALID !== ev || (ev && bus.RES !== 32'd123)) begin
                errs++;
                $display("FAIL b2b[%0d]: ov=%b res=%h required %b 123",
                         i, bus.OUT_VALID, bus.RES, ev);
            end
        end
        bus.OUT_READY = 1'b0;
    endtask

`ifdef PIPELINED_ALU_MUL_EN
    task automatic test_mul();
        int  n;
        logic seen;
        issue(4'd11, 32'h00010000, 32'h00010000);
        n = 0;
        while (!bus.OUT_VALID && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (n + 1 !== W + 1 || bus.RES !== 32'd0 || bus.PSR !== 4'b0101) begin
            errs++;
            $display("FAIL mul_ovf: lat=%0d res=%h psr=%b required %0d 0 0101",
                     n + 1, bus.RES, bus.PSR, W + 1);
        end
        consume();
        issue(4'd11, 32'd1234, 32'd5678);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.OUT_VALID) seen = 1'b1;
            @(posedge CLK);
            #1;
        end
        checks++;
        if (seen !== 1'b0 || bus.IN_READY !== 1'b1 || bus.RES !== 32'd0) begin
            errs++;
            $display("FAIL mul_abort: seen_ov=%b ir=%b res=%h required 0 1 0",
                     seen, bus.IN_READY, bus.RES);
        end
    endtask
`else
    task automatic test_op11_undef();
        issue(4'd11, 32'd6, 32'd7);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.RES !== 32'd0 ||
            bus.PSR !== 4'b0001 || bus.ERR !== 1'b1) begin
            errs++;
            $display("FAIL op11_undef: ov=%b res=%h psr=%b err=%b required 1 0 0001 1",
                     bus.OUT_VALID, bus.RES, bus.PSR, bus.ERR);
        end
        consume();
    endtask
`endif

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.OP1       = '0;
        bus.OP2       = '0;
        bus.OPCode    = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
`ifdef PIPELINED_ALU_MUL_EN
        test_mul();
`else
        test_op11_undef();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
